fc_neuron_engine: RTL and testbench

FC_NEURON_ENGINE -- requirements
Module: fc_neuron_engine

---
 rtl/fc_pkg.sv | 19 +
 rtl/exact_16bit_mult.sv | 12 +
 rtl/fc_requant.sv | 84 ++++++++
 rtl/fc_neuron_engine.sv | 152 +++++++++++++++
 tb/tb_fc_neuron_engine.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fc_pkg.sv
// Shared types and constants for the fully-connected neuron engine.
// Optional output saturation is selected with the OUT_SAT_EN macro (see fc_requant).
package fc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ACCUM = 3'd1,
      ST_REQ1  = 3'd2,
      ST_REQ2  = 3'd3,
      ST_OUT   = 3'd4
   } fc_state_e;

   localparam int ACC_W_DEF  = 32;
   // Effective right shift is SHIFT_BASE - quant_shift, legal only in [TS_MIN, TS_MAX].
   localparam int SHIFT_BASE = 31;
   localparam int TS_MIN     = 1;
   localparam int TS_MAX     = 62;

endpackage

// File: rtl/exact_16bit_mult.sv
// Exact signed 16x16 -> 32-bit multiplier used by the MAC datapath.
module exact_16bit_mult (
   input  logic signed [15:0] i_a,
   input  logic signed [15:0] i_b,
   output logic signed [31:0] o_z
);

   always_comb begin
      o_z = 32'(i_a) * 32'(i_b);
   end

endmodule

// File: rtl/fc_requant.sv
// Requantization: relu, 64-bit scale, rounded arithmetic shift, output zero point.
// Defining OUT_SAT_EN clamps the result to [-128,127] before the byte is taken.
module fc_requant
   import fc_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_ld_p,
   input  logic                    i_ld_out,
   input  logic signed [ACC_W-1:0] i_acc,
   input  logic                    i_relu_en,
   input  logic signed [31:0]      i_quant_mult,
   input  logic signed [31:0]      i_quant_shift,
   input  logic signed [7:0]       i_out_zp,
   output logic [7:0]              o_out,
   output logic                    o_cfg_err
);

   logic signed [ACC_W-1:0] relu_acc;
   logic signed [63:0]      p64_d, p64_q;
   logic signed [33:0]      ts;
   logic                    ts_ok;
   logic [5:0]              ts6;
   logic signed [63:0]      rnd, biased, shifted;
   logic [7:0]              res8;
   logic [7:0]              out_d, out_q;
   logic                    err_d, err_q;
`ifdef OUT_SAT_EN
   logic signed [63:0]      res;
`endif

   always_comb begin
      relu_acc = (i_relu_en && i_acc[ACC_W-1]) ? '0 : i_acc;
      p64_d    = i_ld_p ? (64'(relu_acc) * 64'(i_quant_mult)) : p64_q;
   end

   // Shift amount is range-checked on its full width so wild quant_shift values cannot alias.
   always_comb begin
      ts      = 34'(SHIFT_BASE) - 34'(i_quant_shift);
      ts_ok   = (ts >= 34'(TS_MIN)) && (ts <= 34'(TS_MAX));
      ts6     = ts[5:0];
      rnd     = 64'sd1 <<< (ts6 - 6'd1);
      biased  = p64_q + rnd;
      shifted = biased >>> ts6;
`ifdef OUT_SAT_EN
      res = shifted + 64'(i_out_zp);
      if (res > 64'sd127)
         res8 = 8'h7f;
      else if (res < -64'sd128)
         res8 = 8'h80;
      else
         res8 = 8'(res);
`else
      res8 = 8'(shifted + 64'(i_out_zp));
`endif
   end

   always_comb begin
      out_d = out_q;
      err_d = err_q;
      if (i_ld_out) begin
         out_d = ts_ok ? res8 : i_out_zp;
         err_d = !ts_ok;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         p64_q <= '0;
         out_q <= '0;
         err_q <= 1'b0;
      end else begin
         p64_q <= p64_d;
         out_q <= out_d;
         err_q <= err_d;
      end
   end

   assign o_out     = out_q;
   assign o_cfg_err = err_q;

endmodule

// File: rtl/fc_neuron_engine.sv
// Streaming MAC neuron: accumulates zero-point-corrected products, then requantizes.
// Output saturation is optional via the OUT_SAT_EN macro (applied inside fc_requant).
module fc_neuron_engine
   import fc_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int CNT_W = 16
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic signed [7:0]       i_in_zp,
   input  logic signed [7:0]       i_out_zp,
   input  logic signed [7:0]       i_flt_zp,
   input  logic signed [31:0]      i_quant_mult,
   input  logic signed [31:0]      i_quant_shift,
   input  logic                    i_relu_en,
   input  logic                    i_in_valid,
   output logic                    o_in_ready,
   input  logic signed [7:0]       i_act,
   input  logic signed [7:0]       i_wgt,
   input  logic                    i_last,
   input  logic signed [ACC_W-1:0] i_bias,
   output logic                    o_out_valid,
   input  logic                    i_out_ready,
   output logic [7:0]              o_out,
   output logic                    o_cfg_err,
   output logic [CNT_W-1:0]        o_beat_cnt,
   output fc_state_e               o_dbg_state
);

   // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
   // the producer holds its payload stable while valid is high and ready is low.

   fc_state_e               state_q, state_d;
   logic                    accept, first_beat;
   logic                    ld_p, ld_out;

   logic signed [7:0]       in_zp_q, out_zp_q, flt_zp_q;
   logic signed [31:0]      mult_q, shift_q;
   logic                    relu_q;
   logic signed [7:0]       in_zp_eff, flt_zp_eff;

   logic signed [8:0]       op_a, op_b;
   logic signed [31:0]      prod32;
   logic signed [ACC_W-1:0] acc_base, acc_sum, acc_d, acc_q;
   logic [CNT_W-1:0]        cnt_d, cnt_q;
   logic                    req_err;

   // ---------------- FSM: state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // ---------------- FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept) state_d = i_last ? ST_REQ1 : ST_ACCUM;
         ST_ACCUM: if (accept && i_last) state_d = ST_REQ1;
         ST_REQ1:  state_d = ST_REQ2;
         ST_REQ2:  state_d = ST_OUT;
         ST_OUT:   if (i_out_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs
   always_comb begin
      o_in_ready  = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
      o_out_valid = (state_q == ST_OUT);
      ld_p        = (state_q == ST_REQ1);
      ld_out      = (state_q == ST_REQ2);
   end

   assign accept      = i_in_valid && o_in_ready;
   assign first_beat  = accept && (state_q == ST_IDLE);
   assign o_dbg_state = state_q;

   // The first beat uses live zero points since the latched copy only lands on that edge.
   always_comb begin
      in_zp_eff  = (state_q == ST_IDLE) ? i_in_zp  : in_zp_q;
      flt_zp_eff = (state_q == ST_IDLE) ? i_flt_zp : flt_zp_q;
      op_a       = $signed({i_act[7], i_act}) - $signed({in_zp_eff[7], in_zp_eff});
      op_b       = $signed({i_wgt[7], i_wgt}) - $signed({flt_zp_eff[7], flt_zp_eff});
   end

   exact_16bit_mult u_mult (
      .i_a (16'(op_a)),
      .i_b (16'(op_b)),
      .o_z (prod32)
   );

   always_comb begin
      acc_base = (state_q == ST_IDLE) ? '0 : acc_q;
      acc_sum  = acc_base + ACC_W'(prod32) + (i_last ? i_bias : '0);
      acc_d    = accept ? acc_sum : acc_q;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (first_beat)
         cnt_d = CNT_W'(1);
      else if (accept && !(&cnt_q))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         acc_q    <= '0;
         cnt_q    <= '0;
         in_zp_q  <= '0;
         out_zp_q <= '0;
         flt_zp_q <= '0;
         mult_q   <= '0;
         shift_q  <= '0;
         relu_q   <= 1'b0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         if (first_beat) begin
            in_zp_q  <= i_in_zp;
            out_zp_q <= i_out_zp;
            flt_zp_q <= i_flt_zp;
            mult_q   <= i_quant_mult;
            shift_q  <= i_quant_shift;
            relu_q   <= i_relu_en;
         end
      end
   end

   assign o_beat_cnt = cnt_q;

   fc_requant #(.ACC_W(ACC_W)) u_requant (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_ld_p        (ld_p),
      .i_ld_out      (ld_out),
      .i_acc         (acc_q),
      .i_relu_en     (relu_q),
      .i_quant_mult  (mult_q),
      .i_quant_shift (shift_q),
      .i_out_zp      (out_zp_q),
      .o_out         (o_out),
      .o_cfg_err     (req_err)
   );

   assign o_cfg_err = req_err && o_out_valid;

endmodule

// File: tb/tb_fc_neuron_engine.sv
// Self-checking bench for fc_neuron_engine; honours OUT_SAT_EN in its reference model.
module tb_fc_neuron_engine;
   import fc_pkg::*;

   logic               i_clk = 1'b0;
   logic               i_rst_n;
   logic signed [7:0]  i_in_zp, i_out_zp, i_flt_zp;
   logic signed [31:0] i_quant_mult, i_quant_shift;
   logic               i_relu_en;
   logic               i_in_valid;
   logic               o_in_ready;
   logic signed [7:0]  i_act, i_wgt;
   logic               i_last;
   logic signed [31:0] i_bias;
   logic               o_out_valid;
   logic               i_out_ready;
   logic [7:0]         o_out;
   logic               o_cfg_err;
   logic [15:0]        o_beat_cnt;
   fc_state_e          o_dbg_state;

   fc_neuron_engine dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_in_zp       (i_in_zp),
      .i_out_zp      (i_out_zp),
      .i_flt_zp      (i_flt_zp),
      .i_quant_mult  (i_quant_mult),
      .i_quant_shift (i_quant_shift),
      .i_relu_en     (i_relu_en),
      .i_in_valid    (i_in_valid),
      .o_in_ready    (o_in_ready),
      .i_act         (i_act),
      .i_wgt         (i_wgt),
      .i_last        (i_last),
      .i_bias        (i_bias),
      .o_out_valid   (o_out_valid),
      .i_out_ready   (i_out_ready),
      .o_out         (o_out),
      .o_cfg_err     (o_cfg_err),
      .o_beat_cnt    (o_beat_cnt),
      .o_dbg_state   (o_dbg_state)
   );

   // ---------------- clock
   always #5 i_clk = ~i_clk;

   // ---------------- bookkeeping
   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];
   logic       exp_err_q[$];

   // current vector and configuration
   int v_act[$];
   int v_wgt[$];
   int v_bias;
   int c_in_zp, c_out_zp, c_flt_zp, c_mult, c_shift, c_relu;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: integer arithmetic straight from the neuron definition.
   task automatic model_push();
      int     acc;
      longint p, ts, r;
      logic [7:0] o;
      logic e;
      acc = 0;
      foreach (v_act[i]) acc += (v_act[i] - c_in_zp) * (v_wgt[i] - c_flt_zp);
      acc += v_bias;
      if (c_relu != 0 && acc < 0) acc = 0;
      p  = longint'(acc) * longint'(c_mult);
      ts = 31 - longint'(c_shift);
      if (ts < 1 || ts > 62) begin
         o = 8'(c_out_zp);
         e = 1'b1;
      end else begin
         r = (p + (longint'(1) << (ts - 1))) >>> ts;
         r = r + c_out_zp;
`ifdef OUT_SAT_EN
         if (r > 127) r = 127;
         if (r < -128) r = -128;
`endif
         o = r[7:0];
         e = 1'b0;
      end
      exp_q.push_back(o);
      exp_err_q.push_back(e);
   endtask

   task automatic set_cfg(input int in_zp, input int flt_zp, input int out_zp,
                          input int mult, input int shift, input int relu);
      c_in_zp = in_zp; c_flt_zp = flt_zp; c_out_zp = out_zp;
      c_mult = mult; c_shift = shift; c_relu = relu;
      i_in_zp = 8'(in_zp); i_flt_zp = 8'(flt_zp); i_out_zp = 8'(out_zp);
      i_quant_mult = mult; i_quant_shift = shift; i_relu_en = relu[0];
   endtask

   // Drives the current vector, checks latency, holds off ready for 'stall' cycles, then pops.
   task automatic run_vector(input string tag, input int stall);
      logic [7:0] e_out;
      logic       e_err;
      int         n;
      model_push();
      n = v_act.size();
      for (int i = 0; i < n; i++) begin
         i_in_valid = 1'b1;
         i_act  = 8'(v_act[i]);
         i_wgt  = 8'(v_wgt[i]);
         i_last = (i == n - 1);
         i_bias = v_bias;
         @(posedge i_clk); #1;
      end
      i_in_valid = 1'b0;
      i_last     = 1'b0;
      check({tag, "_lat1"}, o_out_valid, 1'b0);
      check({tag, "_rdy_req"}, o_in_ready, 1'b0);
      @(posedge i_clk); #1;
      check({tag, "_lat2"}, o_out_valid, 1'b0);
      @(posedge i_clk); #1;
      check({tag, "_valid"}, o_out_valid, 1'b1);
      e_out = exp_q.pop_front();
      e_err = exp_err_q.pop_front();
      check({tag, "_out"}, o_out, e_out);
      check({tag, "_err"}, o_cfg_err, e_err);
      check({tag, "_cnt"}, o_beat_cnt, 16'(n));
      for (int s = 0; s < stall; s++) begin
         i_in_valid = 1'b1;
         i_act  = 8'($urandom);
         i_wgt  = 8'($urandom);
         i_last = 1'b1;
         @(posedge i_clk); #1;
         check({tag, "_hold_valid"}, o_out_valid, 1'b1);
         check({tag, "_hold_out"}, o_out, e_out);
         check({tag, "_hold_err"}, o_cfg_err, e_err);
         check({tag, "_hold_rdy"}, o_in_ready, 1'b0);
      end
      if (stall > 0) check({tag, "_hold_cnt"}, o_beat_cnt, 16'(n));
      i_in_valid  = 1'b0;
      i_last      = 1'b0;
      i_out_ready = 1'b1;
      @(posedge i_clk); #1;
      i_out_ready = 1'b0;
      check({tag, "_done_valid"}, o_out_valid, 1'b0);
      check({tag, "_done_state"}, o_dbg_state, ST_IDLE);
      check({tag, "_done_err"}, o_cfg_err, 1'b0);
   endtask

   initial begin
      i_rst_n = 1'b0;
      i_in_valid = 1'b0; i_act = '0; i_wgt = '0; i_last = 1'b0; i_bias = '0;
      i_out_ready = 1'b0;
      set_cfg(0, 0, 0, 0, 0, 0);
      #1;
      check("rst_valid", o_out_valid, 1'b0);
      check("rst_out", o_out, 8'h00);
      check("rst_err", o_cfg_err, 1'b0);
      check("rst_cnt", o_beat_cnt, 16'd0);
      check("rst_state", o_dbg_state, ST_IDLE);
      repeat (3) @(posedge i_clk);
      #1 i_rst_n = 1'b1;
      check("idle_rdy", o_in_ready, 1'b1);

      // two-beat vector with bias, plus a long output stall
      set_cfg(0, 0, 0, 32'h40000000, 0, 1);
      v_act = '{3, -2}; v_wgt = '{4, 5}; v_bias = 10;
      run_vector("basic", 5);
      check("basic_const", exp_q.size(), 0);

      // negative result without relu, then relu with output zero point
      set_cfg(0, 0, 0, 32'h40000000, 0, 0);
      v_act = '{-4}; v_wgt = '{5}; v_bias = 0;
      run_vector("neg", 0);
      set_cfg(0, 0, -5, 32'h40000000, 0, 1);
      run_vector("relu_zp", 1);

      // widest operand difference; truncation vs saturation
      set_cfg(-128, 0, 0, 32'h40000000, 0, 0);
      v_act = '{127}; v_wgt = '{2}; v_bias = 0;
      run_vector("wide", 0);

      // shift out of range reports a configuration error
      set_cfg(0, 0, 7, 32'h40000000, 31, 0);
      v_act = '{1, 2}; v_wgt = '{3, 4}; v_bias = 0;
      run_vector("ts0", 2);

      // asynchronous reset in the middle of a vector
      set_cfg(1, 2, 3, 32'h40000000, 0, 0);
      for (int i = 0; i < 2; i++) begin
         i_in_valid = 1'b1; i_act = 8'(10 + i); i_wgt = 8'(5); i_last = 1'b0;
         @(posedge i_clk); #1;
      end
      i_in_valid = 1'b0;
      check("mid_state", o_dbg_state, ST_ACCUM);
      check("mid_cnt", o_beat_cnt, 16'd2);
      #2 i_rst_n = 1'b0;
      #1;
      check("mid_rst_valid", o_out_valid, 1'b0);
      check("mid_rst_out", o_out, 8'h00);
      check("mid_rst_err", o_cfg_err, 1'b0);
      check("mid_rst_cnt", o_beat_cnt, 16'd0);
      check("mid_rst_state", o_dbg_state, ST_IDLE);
      @(posedge i_clk); #1;
      i_rst_n = 1'b1;
      set_cfg(0, 0, 0, 32'h40000000, 0, 1);
      v_act = '{3, -2}; v_wgt = '{4, 5}; v_bias = 10;
      run_vector("post_rst", 0);

      // randomized vectors and configurations
      for (int k = 0; k < 30; k++) begin
         int n, sh;
         sh = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 1) ? 31 : -32)
                                          : int'($urandom_range(0, 61)) - 31;
         set_cfg(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                 int'($urandom_range(0, 255)) - 128, int'($urandom), sh,
                 int'($urandom_range(0, 1)));
         n = int'($urandom_range(1, 6));
         v_act.delete(); v_wgt.delete();
         for (int i = 0; i < n; i++) begin
            v_act.push_back(int'($urandom_range(0, 255)) - 128);
            v_wgt.push_back(int'($urandom_range(0, 255)) - 128);
         end
         v_bias = int'($urandom_range(0, 4000)) - 2000;
         run_vector($sformatf("rnd%0d", k), int'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Safety net so the run always ends on its own.
   initial begin
      #200000;
      errors++;
      $display("FAIL timeout: observed=running expected=finished");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
